button_debounce: RTL

Debounced push-button input conditioner for the iCESugar-Nano, the input-side counterpart to the LED blink drivers. Synchronises one raw button pin into the `CLK` domain, filters contact bounce with a counter-based state machine, and emits a clean level plus single-cycle press, release and long-press events. Blink-rate selectors and mode toggles consume these events directly.

---
 rtl/button_pkg.sv | 19 +
 rtl/button_sync.sv | 30 +++
 rtl/button_debounce.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button input path.
//   btn_state_t         : debounce FSM states
//   CLK_HZ              : board system clock (36 MHz)
//   DEBOUNCE_CYCLES_DEF : 10 ms of stable samples at CLK_HZ
//   LONG_CYCLES_DEF     : 1 s long-press threshold at CLK_HZ
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        HELD,
        DISARMING
    } btn_state_t;

    localparam int unsigned CLK_HZ              = 36000000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
    localparam int unsigned LONG_CYCLES_DEF     = CLK_HZ;

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser for a single asynchronous pin.
//   CLK   : destination clock
//   RST_N : async active-low reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output
module button_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Debounced push-button conditioner.
//   CLK     : system clock, rising edge
//   RST_N   : async active-low reset
//   BTN     : raw asynchronous button pin
//   PRESSED : debounced level, 1 while the button is accepted as held
//   PRESS   : one-cycle pulse on each accepted press
//   RELEASE : one-cycle pulse on each accepted release
//   LONG    : one-cycle pulse once per press after LONG_CYCLES of holding
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic PRESSED,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LMAX = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LSAT = LW'(LONG_CYCLES);

    logic act;

    // Normalise polarity before synchronising so the reset level is always "not pressed".
    button_sync #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (BTN ^ ACTIVE_LOW),
        .q     (act)
    );

    btn_state_t    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        lcnt_d    = lcnt_q;
        press_d   = 1'b0;
        rel_d     = 1'b0;
        long_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (act) begin
                    state_d = ARMING;
                    dcnt_d  = DW'(1);
                end
            end
            ARMING: begin
                if (!act) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DMAX) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                    lcnt_d  = '0;
                    press_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            HELD: begin
                // Timer runs every HELD cycle and parks at LSAT so LONG fires once per press.
                if (lcnt_q != LSAT) begin
                    lcnt_d = lcnt_q + LW'(1);
                end
                if (lcnt_q == LMAX) begin
                    long_d = 1'b1;
                end
                if (!act) begin
                    state_d = DISARMING;
                    dcnt_d  = DW'(1);
                end
            end
            DISARMING: begin
                // lcnt is frozen here: a release bounce pauses the long-press timer.
                if (act) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                end else if (dcnt_q == DMAX) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                    rel_d   = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
            end
        endcase

        pressed_d = (state_d == HELD) || (state_d == DISARMING);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            lcnt_q    <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            lcnt_q    <= lcnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            long_q    <= long_d;
        end
    end

    assign PRESSED = pressed_q;
    assign PRESS   = press_q;
    assign RELEASE = rel_q;
    assign LONG    = long_q;

endmodule
